// File: rtl/display_capture_4digit_pkg.sv
// Shared 7-segment table and decode codes for the display driver and the capture monitor.
package display_capture_4digit_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DEC_W      = 4;

    // {a,b,c,d,e,f,g}, active-high
    localparam logic [SEG_W-1:0] SEG_0   = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

    localparam logic [DEC_W-1:0] DEC_OFF = 4'hF;
    localparam logic [DEC_W-1:0] DEC_BAD = 4'hE;

endpackage

// File: rtl/segs27dec.sv
// Combinational inverse of the driver's dec27segs encoder: {a..g} -> dec code plus illegal flag.
module segs27dec
    import display_capture_4digit_pkg::*;
(
    input  logic [SEG_W-1:0] segs,
    output logic [DEC_W-1:0] dec_c,
    output logic             bad_c
);

    always_comb begin
        dec_c = DEC_BAD;
        bad_c = 1'b0;
        case (segs)
            SEG_0:   dec_c = 4'h0;
            SEG_1:   dec_c = 4'h1;
            SEG_2:   dec_c = 4'h2;
            SEG_3:   dec_c = 4'h3;
            SEG_4:   dec_c = 4'h4;
            SEG_5:   dec_c = 4'h5;
            SEG_6:   dec_c = 4'h6;
            SEG_7:   dec_c = 4'h7;
            SEG_8:   dec_c = 4'h8;
            SEG_9:   dec_c = 4'h9;
            SEG_OFF: dec_c = DEC_OFF;
            default: bad_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/display_capture_4digit.sv
// Display bus monitor: debounces each strobed digit, decodes it back to dec/dp, and tracks
// frame completion, bus liveness and sticky protocol errors.
module display_capture_4digit
    import display_capture_4digit_pkg::*;
#(
    parameter int unsigned CONFIRM = 2,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  segments,
    input  logic [3:0]  digits,
    output logic [15:0] decs,
    output logic [3:0]  points,
    output logic        valid,
    output logic        frame_done,
    output logic        err_pattern,
    output logic        err_strobe
);

    localparam int unsigned CW = $clog2(CONFIRM + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    logic [DEC_W-1:0]      dec_c;
    logic                  bad_c;
    logic                  strobe_ok_c;
    logic                  strobe_multi_c;
    logic [NUM_DIGITS-1:0] conf_c;

    logic [15:0]           decs_q, decs_d;
    logic [3:0]            points_q, points_d;
    logic                  valid_q, valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_pattern_q, err_pattern_d;
    logic                  err_strobe_q, err_strobe_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    segs27dec u_dec (
        .segs  (segments[7:1]),
        .dec_c (dec_c),
        .bad_c (bad_c)
    );

    // Legal strobe is exactly one bit; zero is idle, anything else is a bus fault.
    assign strobe_ok_c    = (digits != 4'h0) && ((digits & (digits - 4'h1)) == 4'h0);
    assign strobe_multi_c = (digits != 4'h0) && !strobe_ok_c;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slice
        logic [7:0]    shadow_q, shadow_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          hit_c;

        assign hit_c = strobe_ok_c && digits[gi];

        // A changed pattern restarts the run; a repeat counts up and saturates at CONFIRM.
        always_comb begin
            shadow_d = shadow_q;
            cnt_d    = cnt_q;
            if (hit_c) begin
                if (segments != shadow_q) begin
                    shadow_d = segments;
                    cnt_d    = CW'(1);
                end else if (cnt_q != CW'(CONFIRM)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        assign conf_c[gi] = hit_c && (cnt_d == CW'(CONFIRM));

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_q <= '0;
                cnt_q    <= '0;
            end else begin
                shadow_q <= shadow_d;
                cnt_q    <= cnt_d;
            end
        end
    end

    always_comb begin
        decs_d        = decs_q;
        points_d      = points_q;
        valid_d       = valid_q;
        frame_done_d  = 1'b0;
        err_pattern_d = err_pattern_q;
        err_strobe_d  = err_strobe_q;
        seen_d        = seen_q;
        tmo_d         = tmo_q;

        // A full mask closes the frame; a confirmation this cycle belongs to the next one.
        if (seen_q == 4'hF) begin
            frame_done_d = 1'b1;
            valid_d      = 1'b1;
            seen_d       = '0;
        end
        seen_d = seen_d | conf_c;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (conf_c[i]) begin
                decs_d[4*i +: 4] = dec_c;
                points_d[i]      = segments[0];
            end
        end

        if (strobe_multi_c)        err_strobe_d  = 1'b1;
        if (strobe_ok_c && bad_c)  err_pattern_d = 1'b1;

        // Liveness: any legal strobe reloads; otherwise count and saturate at expiry.
        if (strobe_ok_c) begin
            tmo_d = '0;
        end else begin
            if (tmo_q != TW'(TIMEOUT - 1)) tmo_d = tmo_q + TW'(1);
            if (tmo_d == TW'(TIMEOUT - 1)) begin
                valid_d = 1'b0;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            decs_q        <= 16'hFFFF;
            points_q      <= '0;
            valid_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            err_pattern_q <= 1'b0;
            err_strobe_q  <= 1'b0;
            seen_q        <= '0;
            tmo_q         <= '0;
        end else begin
            decs_q        <= decs_d;
            points_q      <= points_d;
            valid_q       <= valid_d;
            frame_done_q  <= frame_done_d;
            err_pattern_q <= err_pattern_d;
            err_strobe_q  <= err_strobe_d;
            seen_q        <= seen_d;
            tmo_q         <= tmo_d;
        end
    end

    assign decs        = decs_q;
    assign points      = points_q;
    assign valid       = valid_q;
    assign frame_done  = frame_done_q;
    assign err_pattern = err_pattern_q;
    assign err_strobe  = err_strobe_q;

endmodule

// File: tb/tb_display_capture_4digit.sv
// Bench for display_capture_4digit: directed vector table, hand sequences for timeout/reset,
// and a randomized run against an array-based reference model.
module tb_display_capture_4digit;

    localparam int unsigned CONFIRM = 2;
    localparam int unsigned TIMEOUT = 256;

    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] PB = 7'b1000001;

    // decs=16'h1234 (D1=4 .. D4=1), points=4'b0101
    localparam logic [7:0] SD1 = {P4, 1'b1};
    localparam logic [7:0] SD2 = {P3, 1'b0};
    localparam logic [7:0] SD3 = {P2, 1'b1};
    localparam logic [7:0] SD4 = {P1, 1'b0};
    localparam logic [7:0] SG8 = {P8, 1'b0};
    localparam logic [7:0] SBD = {PB, 1'b0};

    logic        clk;
    logic        rst;
    logic [7:0]  segments;
    logic [3:0]  digits;
    logic [15:0] decs;
    logic [3:0]  points;
    logic        valid;
    logic        frame_done;
    logic        err_pattern;
    logic        err_strobe;

    display_capture_4digit #(.CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .segments    (segments),
        .digits      (digits),
        .decs        (decs),
        .points      (points),
        .valid       (valid),
        .frame_done  (frame_done),
        .err_pattern (err_pattern),
        .err_strobe  (err_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [6:0] pat [10];
    logic [7:0] m_shadow [4];
    int         m_cnt [4];
    logic [3:0] m_dec [4];
    bit         m_pt [4];
    bit         m_seen [4];
    int         m_idle;
    bit         m_valid, m_fd, m_errp, m_errs;

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] d, output bit bad);
        d   = 4'hE;
        bad = 1'b1;
        if (p == 7'd0) begin
            d   = 4'hF;
            bad = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            if (pat[k] == p) begin
                d   = 4'(k);
                bad = 1'b0;
            end
        end
    endfunction

    function automatic void model_step(input bit r, input logic [3:0] dg, input logic [7:0] sg);
        int         n;
        int         idx;
        logic [3:0] d;
        bit         bad;
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                m_shadow[k] = 8'h00; m_cnt[k] = 0; m_dec[k] = 4'hF; m_pt[k] = 1'b0; m_seen[k] = 1'b0;
            end
            m_idle = 0; m_valid = 0; m_fd = 0; m_errp = 0; m_errs = 0;
            return;
        end
        m_fd = 0;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
            m_fd = 1; m_valid = 1;
            for (int k = 0; k < 4; k++) m_seen[k] = 1'b0;
        end
        n = $countones(dg);
        if (n > 1) m_errs = 1;
        if (n == 1) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (dg[k]) idx = k;
            ref_decode(sg[7:1], d, bad);
            if (bad) m_errp = 1;
            if (sg == m_shadow[idx]) begin
                m_cnt[idx] = (m_cnt[idx] + 1 > int'(CONFIRM)) ? int'(CONFIRM) : m_cnt[idx] + 1;
            end else begin
                m_shadow[idx] = sg;
                m_cnt[idx]    = 1;
            end
            if (m_cnt[idx] == int'(CONFIRM)) begin
                m_dec[idx] = d; m_pt[idx] = sg[0]; m_seen[idx] = 1'b1;
            end
            m_idle = 0;
        end else begin
            if (m_idle < int'(TIMEOUT) - 1) m_idle++;
            if (m_idle == int'(TIMEOUT) - 1) begin
                m_valid = 0;
                for (int k = 0; k < 4; k++) m_seen[k] = 1'b0;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input logic [3:0] dg, input logic [7:0] sg);
        rst      = r;
        digits   = dg;
        segments = sg;
        @(posedge clk);
        model_step(r, dg, sg);
        #1;
    endtask

    task automatic rotate();
        step(1'b0, 4'b0001, SD1);
        step(1'b0, 4'b0010, SD2);
        step(1'b0, 4'b0100, SD3);
        step(1'b0, 4'b1000, SD4);
    endtask

    task automatic chk_model();
        chk("rnd_decs",  32'(decs),
            32'({m_dec[3], m_dec[2], m_dec[1], m_dec[0]}));
        chk("rnd_points", 32'(points), 32'({m_pt[3], m_pt[2], m_pt[1], m_pt[0]}));
        chk("rnd_valid",  32'(valid),       32'(m_valid));
        chk("rnd_frame",  32'(frame_done),  32'(m_fd));
        chk("rnd_errpat", 32'(err_pattern), 32'(m_errp));
        chk("rnd_errstb", 32'(err_strobe),  32'(m_errs));
    endtask

    typedef struct {
        bit         r;
        logic [3:0] dg;
        logic [7:0] sg;
        logic [15:0] decs;
        logic [3:0] pts;
        bit         v, fd, ep, es;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input bit r, input logic [3:0] dg, input logic [7:0] sg, input logic [15:0] dc,
                       input logic [3:0] pt, input bit v, input bit fd, input bit ep, input bit es);
        vec_t e;
        e.r = r; e.dg = dg; e.sg = sg; e.decs = dc; e.pts = pt; e.v = v; e.fd = fd; e.ep = ep; e.es = es;
        tbl.push_back(e);
    endtask

    logic [7:0] cur [4];
    logic [7:0] sg_r;
    logic [3:0] dg_r;
    int         rv, dsel, burst;

    initial begin
        pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
        pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b1011111; pat[7] = 7'b1110000;
        pat[8] = 7'b1111111; pat[9] = 7'b1111011;
        rst = 1'b1; digits = 4'h0; segments = 8'h00;

        // reset, two rotations, glitch rejection, strobe/pattern errors, reset again
        add(1, 4'h0, 8'h00, 16'hFFFF, 4'b0000, 0, 0, 0, 0);
        add(0, 4'h1, SD1,   16'hFFFF, 4'b0000, 0, 0, 0, 0);
        add(0, 4'h2, SD2,   16'hFFFF, 4'b0000, 0, 0, 0, 0);
        add(0, 4'h4, SD3,   16'hFFFF, 4'b0000, 0, 0, 0, 0);
        add(0, 4'h8, SD4,   16'hFFFF, 4'b0000, 0, 0, 0, 0);
        add(0, 4'h1, SD1,   16'hFFF4, 4'b0001, 0, 0, 0, 0);
        add(0, 4'h2, SD2,   16'hFF34, 4'b0001, 0, 0, 0, 0);
        add(0, 4'h4, SD3,   16'hF234, 4'b0101, 0, 0, 0, 0);
        add(0, 4'h8, SD4,   16'h1234, 4'b0101, 0, 0, 0, 0);
        add(0, 4'h0, 8'h00, 16'h1234, 4'b0101, 1, 1, 0, 0);
        add(0, 4'h0, 8'h00, 16'h1234, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h1, SD1,   16'h1234, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h2, SD2,   16'h1234, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h4, SD3,   16'h1234, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h8, SD4,   16'h1234, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h0, 8'h00, 16'h1234, 4'b0101, 1, 1, 0, 0);
        add(0, 4'h2, SG8,   16'h1234, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h2, SD2,   16'h1234, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h2, SG8,   16'h1234, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h2, SG8,   16'h1284, 4'b0101, 1, 0, 0, 0);
        add(0, 4'h6, SD1,   16'h1284, 4'b0101, 1, 0, 0, 1);
        add(0, 4'h8, SBD,   16'h1284, 4'b0101, 1, 0, 1, 1);
        add(0, 4'h8, SBD,   16'hE284, 4'b0101, 1, 0, 1, 1);
        add(0, 4'h0, 8'h00, 16'hE284, 4'b0101, 1, 0, 1, 1);
        add(1, 4'h1, SD1,   16'hFFFF, 4'b0000, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].dg, tbl[i].sg);
            chk($sformatf("vec%0d_decs", i),   32'(decs),        32'(tbl[i].decs));
            chk($sformatf("vec%0d_points", i), 32'(points),      32'(tbl[i].pts));
            chk($sformatf("vec%0d_valid", i),  32'(valid),       32'(tbl[i].v));
            chk($sformatf("vec%0d_frame", i),  32'(frame_done),  32'(tbl[i].fd));
            chk($sformatf("vec%0d_errpat", i), 32'(err_pattern), 32'(tbl[i].ep));
            chk($sformatf("vec%0d_errstb", i), 32'(err_strobe),  32'(tbl[i].es));
        end

        // Timeout: valid drops on the 255th idle clock, decs held; a strobe on that clock prevents it.
        rotate(); rotate();
        chk("tmo_valid_before_pulse", 32'(valid), 32'(0));
        for (int j = 0; j < 254; j++) step(1'b0, 4'h0, 8'h00);
        chk("tmo_valid_at_254", 32'(valid), 32'(1));
        step(1'b0, 4'h0, 8'h00);
        chk("tmo_valid_at_255", 32'(valid), 32'(0));
        chk("tmo_decs_held",    32'(decs),  32'(16'h1234));
        step(1'b0, 4'h0, 8'h00);
        chk("tmo_valid_hold_low", 32'(valid), 32'(0));
        rotate();
        step(1'b0, 4'h0, 8'h00);
        chk("tmo_refill_frame", 32'(frame_done), 32'(1));
        chk("tmo_refill_valid", 32'(valid),      32'(1));
        for (int j = 0; j < 253; j++) step(1'b0, 4'h0, 8'h00);
        step(1'b0, 4'h1, SD1);
        chk("tmo_expiry_strobe_valid", 32'(valid), 32'(1));
        step(1'b0, 4'h0, 8'h00);
        chk("tmo_after_expiry_strobe", 32'(valid), 32'(1));

        // Mid-frame reset discards partial progress.
        step(1'b1, 4'h0, 8'h00);
        step(1'b0, 4'h1, SD1); step(1'b0, 4'h2, SD2); step(1'b0, 4'h1, SD1); step(1'b0, 4'h2, SD2);
        chk("mid_decs_partial", 32'(decs), 32'(16'hFF34));
        step(1'b1, 4'h4, SD3);
        chk("mid_rst_decs",   32'(decs),   32'(16'hFFFF));
        chk("mid_rst_points", 32'(points), 32'(0));
        chk("mid_rst_valid",  32'(valid),  32'(0));
        rotate();
        chk("mid_first_rot_decs", 32'(decs), 32'(16'hFFFF));
        rotate();
        chk("mid_second_rot_decs",  32'(decs),  32'(16'h1234));
        chk("mid_second_rot_valid", 32'(valid), 32'(0));
        step(1'b0, 4'h0, 8'h00);
        chk("mid_frame_valid", 32'(valid),      32'(1));
        chk("mid_frame_pulse", 32'(frame_done), 32'(1));

        // Randomized traffic against the reference model.
        step(1'b1, 4'h0, 8'h00);
        for (int d = 0; d < 4; d++) cur[d] = {pat[$urandom_range(9)], 1'($urandom_range(1))};
        for (int n = 0; n < 3000; n++) begin
            rv = int'($urandom_range(999));
            if (rv < 3) begin
                step(1'b1, 4'($urandom_range(15)), 8'($urandom_range(255)));
                chk_model();
            end else if (rv < 8) begin
                burst = int'($urandom_range(240, 270));
                for (int j = 0; j < burst; j++) begin
                    step(1'b0, 4'h0, 8'($urandom_range(255)));
                    chk_model();
                end
            end else if (rv < 14) begin
                dg_r = 4'($urandom_range(3, 15));
                if ($countones(dg_r) < 2) dg_r = 4'b1001;
                step(1'b0, dg_r, 8'($urandom_range(255)));
                chk_model();
            end else if (rv < 250) begin
                step(1'b0, 4'h0, 8'($urandom_range(255)));
                chk_model();
            end else begin
                dsel = int'($urandom_range(3));
                if ($urandom_range(99) < 4) begin
                    if ($urandom_range(9) == 0) cur[dsel] = 8'($urandom_range(255));
                    else cur[dsel] = {pat[$urandom_range(9)], 1'($urandom_range(1))};
                end
                sg_r = cur[dsel];
                if ($urandom_range(99) < 3) sg_r = {pat[$urandom_range(9)], 1'($urandom_range(1))};
                step(1'b0, 4'(1 << dsel), sg_r);
                chk_model();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
